// File: rtl/general_register_file.sv
// rtl/general_register_file.sv - eight-entry operand register bank feeding the ALU A/B buses
//
// Purpose:
//   Holds general-purpose registers R1-R4 and scratch registers S1-S4. Every
//   enabled register applies the same FunSel operation on the rising edge of
//   Clock, each using its own previous value. Two combinational read ports
//   select any register for the ALU operand buses.
//
// Ports:
//   Clock    in   system clock, rising-edge active
//   Reset    in   asynchronous, active-high; clears every register
//   I        in   write/load data
//   FunSel   in   operation applied to all enabled registers
//   RegSel   in   bit3..0 = R1..R4 write enables
//   ScrSel   in   bit3..0 = S1..S4 write enables
//   OutASel  in   read select A: 0-3 = R1-R4, 4-7 = S1-S4
//   OutBSel  in   read select B, same encoding
//   OutA     out  selected register, ALU operand A
//   OutB     out  selected register, ALU operand B

module general_register_file #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [3:0]       RegSel,
  input  logic [3:0]       ScrSel,
  input  logic [2:0]       OutASel,
  input  logic [2:0]       OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);

  // Storage index 0-3 = R1-R4, 4-7 = S1-S4, matching the read-select encoding.
  logic [WIDTH-1:0] r_regs [0:7];
  logic [WIDTH-1:0] w_next [0:7];
  logic [7:0]       w_en;

  function automatic logic [WIDTH-1:0] f_next(input logic [WIDTH-1:0] q,
                                              input logic [WIDTH-1:0] d,
                                              input logic [2:0]       fs);
    logic [WIDTH-1:0] v;
    v = q;
    case (fs)
      3'b000:  v = q - WIDTH'(1);
      3'b001:  v = q + WIDTH'(1);
      3'b010:  v = d;
      3'b011:  v = '0;
      3'b100:  v = {{(WIDTH-8){1'b0}}, d[7:0]};
      3'b101:  v = {q[WIDTH-1:8], d[7:0]};
      3'b110:  v = {q[WIDTH-1:16], d[7:0], q[7:0]};
      default: v = {{(WIDTH-16){d[15]}}, d[15:0]};
    endcase
    return v;
  endfunction

  // Select bits are MSB-first (bit3 = first register), so reverse them here.
  always_comb begin
    w_en = '0;
    for (int i = 0; i < 4; i++) begin
      w_en[i]   = RegSel[3-i];
      w_en[i+4] = ScrSel[3-i];
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_next[i] = f_next(r_regs[i], I, FunSel);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_en[i]) begin
          r_regs[i] <= w_next[i];
        end
      end
    end
  end

  // No write-through: reads show state as of the last edge.
  assign OutA = r_regs[OutASel];
  assign OutB = r_regs[OutBSel];

endmodule

// File: tb/tb_general_register_file.sv
// tb/tb_general_register_file.sv - directed self-checking bench for general_register_file

module tb_general_register_file;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] I;
  logic [2:0]  FunSel;
  logic [3:0]  RegSel;
  logic [3:0]  ScrSel;
  logic [2:0]  OutASel;
  logic [2:0]  OutBSel;
  logic [31:0] OutA;
  logic [31:0] OutB;

  int total = 0;
  int bad   = 0;

  general_register_file #(.WIDTH(32)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .I       (I),
    .FunSel  (FunSel),
    .RegSel  (RegSel),
    .ScrSel  (ScrSel),
    .OutASel (OutASel),
    .OutBSel (OutBSel),
    .OutA    (OutA),
    .OutB    (OutB)
  );

  always #5 Clock = ~Clock;

  // Apply one operation for a single edge, then drop all enables.
  task automatic op(input logic [2:0] f, input logic [3:0] rs, input logic [3:0] ss,
                    input logic [31:0] d);
    FunSel = f;
    RegSel = rs;
    ScrSel = ss;
    I      = d;
    @(posedge Clock);
    #1;
    RegSel = 4'b0000;
    ScrSel = 4'b0000;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      OutASel = 3'(i);
      OutBSel = 3'(7 - i);
      #1;
      total++;
      if (OutA !== 32'h0 || OutB !== 32'h0) begin
        bad++;
        $display("FAIL reset_reg%0d: OutA=%h OutB=%h expected 00000000", i, OutA, OutB);
      end
    end
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_reset_mid;
    OutASel = 3'd0;
    op(3'b010, 4'b1000, 4'b0000, 32'h12345678);
    total++;
    if (OutA !== 32'h12345678) begin
      bad++;
      $display("FAIL rst_mid_load: OutA=%h expected 12345678", OutA);
    end
    #2;
    Reset = 1'b1;
    #1;
    total++;
    if (OutA !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid_async: OutA=%h expected 00000000", OutA);
    end
    FunSel = 3'b010;
    RegSel = 4'b1000;
    I      = 32'hCAFEF00D;
    @(posedge Clock);
    #1;
    total++;
    if (OutA !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid_edge_ignored: OutA=%h expected 00000000", OutA);
    end
    RegSel = 4'b0000;
    Reset  = 1'b0;
    @(posedge Clock);
    #1;
    total++;
    if (OutA !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid_after: OutA=%h expected 00000000", OutA);
    end
  endtask

  task automatic test_load_dual;
    op(3'b010, 4'b0101, 4'b0000, 32'hDEADBEEF);
    OutASel = 3'd1;
    OutBSel = 3'd3;
    #1;
    total++;
    if (OutA !== 32'hDEADBEEF || OutB !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL load_dual: OutA=%h OutB=%h expected deadbeef", OutA, OutB);
    end
    OutASel = 3'd0;
    OutBSel = 3'd2;
    #1;
    total++;
    if (OutA !== 32'h0 || OutB !== 32'h0) begin
      bad++;
      $display("FAIL load_unselected: R1=%h R3=%h expected 00000000", OutA, OutB);
    end
  endtask

  task automatic test_wrap;
    OutASel = 3'd4;
    op(3'b010, 4'b0000, 4'b1000, 32'hFFFFFFFF);
    op(3'b001, 4'b0000, 4'b1000, 32'h0);
    total++;
    if (OutA !== 32'h00000000) begin
      bad++;
      $display("FAIL wrap_inc: S1=%h expected 00000000", OutA);
    end
    op(3'b000, 4'b0000, 4'b1000, 32'h0);
    total++;
    if (OutA !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL wrap_dec1: S1=%h expected ffffffff", OutA);
    end
    op(3'b000, 4'b0000, 4'b1000, 32'h0);
    total++;
    if (OutA !== 32'hFFFFFFFE) begin
      bad++;
      $display("FAIL wrap_dec2: S1=%h expected fffffffe", OutA);
    end
  endtask

  task automatic test_partial;
    OutASel = 3'd2;
    op(3'b010, 4'b0010, 4'b0000, 32'hAABBCCDD);
    op(3'b101, 4'b0010, 4'b0000, 32'h00000011);
    total++;
    if (OutA !== 32'hAABBCC11) begin
      bad++;
      $display("FAIL partial_low: R3=%h expected aabbcc11", OutA);
    end
    op(3'b110, 4'b0010, 4'b0000, 32'h00000022);
    total++;
    if (OutA !== 32'hAABB2211) begin
      bad++;
      $display("FAIL partial_mid: R3=%h expected aabb2211", OutA);
    end
    op(3'b100, 4'b0010, 4'b0000, 32'hFFFFFF33);
    total++;
    if (OutA !== 32'h00000033) begin
      bad++;
      $display("FAIL partial_clrbyte: R3=%h expected 00000033", OutA);
    end
  endtask

  task automatic test_sign;
    OutBSel = 3'd7;
    op(3'b111, 4'b0000, 4'b0001, 32'h00008001);
    total++;
    if (OutB !== 32'hFFFF8001) begin
      bad++;
      $display("FAIL sign_neg: S4=%h expected ffff8001", OutB);
    end
    op(3'b111, 4'b0000, 4'b0001, 32'hFFFF7FFF);
    total++;
    if (OutB !== 32'h00007FFF) begin
      bad++;
      $display("FAIL sign_pos: S4=%h expected 00007fff", OutB);
    end
  endtask

  task automatic test_rdw_inc;
    op(3'b010, 4'b1000, 4'b0000, 32'd5);
    op(3'b010, 4'b0000, 4'b0100, 32'd9);
    FunSel  = 3'b001;
    RegSel  = 4'b1000;
    ScrSel  = 4'b0100;
    OutASel = 3'd0;
    OutBSel = 3'd5;
    #1;
    total++;
    if (OutA !== 32'd5) begin
      bad++;
      $display("FAIL rdw_before_early: OutA=%h expected 00000005", OutA);
    end
    @(negedge Clock);
    #3;
    total++;
    if (OutA !== 32'd5 || OutB !== 32'd9) begin
      bad++;
      $display("FAIL rdw_before_late: OutA=%h OutB=%h expected 5/9", OutA, OutB);
    end
    @(posedge Clock);
    #1;
    RegSel = 4'b0000;
    ScrSel = 4'b0000;
    total++;
    if (OutA !== 32'd6 || OutB !== 32'd10) begin
      bad++;
      $display("FAIL rdw_after: OutA=%h OutB=%h expected 6/10", OutA, OutB);
    end
    OutBSel = 3'd0;
    #1;
    total++;
    if (OutB !== 32'd6) begin
      bad++;
      $display("FAIL same_sel: OutB=%h expected 00000006", OutB);
    end
  endtask

  task automatic test_clear;
    op(3'b011, 4'b1111, 4'b1111, 32'hFFFFFFFF);
    for (int i = 0; i < 8; i++) begin
      OutASel = 3'(i);
      #1;
      total++;
      if (OutA !== 32'h0) begin
        bad++;
        $display("FAIL clear_reg%0d: OutA=%h expected 00000000", i, OutA);
      end
    end
  endtask

  initial begin
    Reset   = 1'b1;
    I       = 32'h0;
    FunSel  = 3'b000;
    RegSel  = 4'b0000;
    ScrSel  = 4'b0000;
    OutASel = 3'd0;
    OutBSel = 3'd0;
    test_reset();
    test_reset_mid();
    test_load_dual();
    test_wrap();
    test_partial();
    test_sign();
    test_rdw_inc();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
